// File: rtl/cpu_mem_bridge_pkg.sv
// Shared definitions for the Z80 CPU to slow-memory bridge.
package cpu_mem_bridge_pkg;

  localparam int unsigned CNT_W           = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam logic [7:0]  IDLE_BUS        = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/cpu_mem_bridge_timeout_cnt.sv
// Clear/enable counter that flags when it sits on its terminal value.
module bridge_timeout_cnt
  import cpu_mem_bridge_pkg::*;
#(
  parameter int unsigned TERM_VAL = TIMEOUT_DEFAULT - 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term_c
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_term_c = (r_count == CNT_W'(TERM_VAL));

endmodule

// File: rtl/cpu_mem_bridge.sv
// Stalls the Z80 with WAIT while one level-request access completes on slow memory.
module cpu_mem_bridge
  import cpu_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_rfsh_n,
  input  logic        cpu_m1_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  output logic        cpu_wait_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  bridge_state_e r_state, w_state_nxt;
  logic          r_mem_req,   w_mem_req_nxt;
  logic          r_wait_n,    w_wait_n_nxt;
  logic          r_mem_we,    w_mem_we_nxt;
  logic [15:0]   r_mem_addr,  w_mem_addr_nxt;
  logic [7:0]    r_mem_wdata, w_mem_wdata_nxt;
  logic [7:0]    r_cpu_di,    w_cpu_di_nxt;
  logic          r_bus_err,   w_bus_err_nxt;
  logic          w_cnt_clr, w_cnt_en, w_cnt_term;
  logic          w_start, w_io_rd;

  // Refresh and IO cycles never reach memory.
  assign w_start = !cpu_mreq_n && cpu_iorq_n && cpu_rfsh_n && (!cpu_rd_n || !cpu_wr_n);
  assign w_io_rd = !cpu_iorq_n && ((!cpu_rd_n && cpu_m1_n) || !cpu_m1_n);

  bridge_timeout_cnt #(
    .TERM_VAL (TIMEOUT - 1)
  ) u_timeout_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_term_c (w_cnt_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_wait_n    <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_di    <= IDLE_BUS;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_wait_n    <= w_wait_n_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_cpu_di    <= w_cpu_di_nxt;
      r_bus_err   <= w_bus_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_wait_n_nxt    = r_wait_n;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_cpu_di_nxt    = r_cpu_di;
    w_bus_err_nxt   = r_bus_err;
    w_cnt_clr       = 1'b0;
    w_cnt_en        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt     = ST_WAIT;
          w_mem_req_nxt   = 1'b1;
          w_wait_n_nxt    = 1'b0;
          w_mem_addr_nxt  = cpu_a;
          w_mem_we_nxt    = !cpu_wr_n;
          w_mem_wdata_nxt = cpu_dout;
          w_cnt_clr       = 1'b1;
        end else if (w_io_rd) begin
          w_cpu_di_nxt = IDLE_BUS;
        end
      end
      ST_WAIT: begin
        // An acknowledge on the terminal cycle still counts as success.
        if (mem_ack) begin
          w_state_nxt   = ST_DONE;
          w_mem_req_nxt = 1'b0;
          w_wait_n_nxt  = 1'b1;
          if (!r_mem_we) begin
            w_cpu_di_nxt = mem_rdata;
          end
        end else if (w_cnt_term) begin
          w_state_nxt   = ST_DONE;
          w_mem_req_nxt = 1'b0;
          w_wait_n_nxt  = 1'b1;
          w_cpu_di_nxt  = IDLE_BUS;
          w_bus_err_nxt = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        if (cpu_mreq_n) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cpu_di     = r_cpu_di;
  assign cpu_wait_n = r_wait_n;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Randomized bench for cpu_mem_bridge against a transaction-level expectation model.
module tb_cpu_mem_bridge;

  localparam int unsigned TMO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_m1_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_di;
  logic        cpu_wait_n;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: what the CPU should see on cpu_di and bus_err.
  logic [7:0] exp_di  = 8'hFF;
  logic       exp_err = 1'b0;

  always #5 clk = ~clk;

  cpu_mem_bridge #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_mreq_n (cpu_mreq_n),
    .cpu_iorq_n (cpu_iorq_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_rfsh_n (cpu_rfsh_n),
    .cpu_m1_n   (cpu_m1_n),
    .cpu_a      (cpu_a),
    .cpu_dout   (cpu_dout),
    .cpu_di     (cpu_di),
    .cpu_wait_n (cpu_wait_n),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .bus_err    (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1;
    cpu_wr_n   = 1'b1; cpu_rfsh_n = 1'b1; cpu_m1_n = 1'b1;
  endtask

  // One memory access: CPU strobes, memory acks lat cycles after mem_req rises.
  task automatic do_mem(input bit wr, input logic [15:0] a, input logic [7:0] d,
                        input int lat, input logic [7:0] rd, input int hold);
    int stall = 0;
    int reqs = 0;
    int k = 0;
    int extra = 0;
    int bad_wait = 0;
    bit done = 0;
    bit prev_req = 0;
    logic [15:0] cap_a = '0;
    logic        cap_we = 1'b0;
    logic [7:0]  cap_wd = '0;
    int exp_stall;
    cpu_a = a; cpu_dout = d; cpu_mreq_n = 1'b0;
    if (wr) begin
      cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
      step();
      chk("wr_setup_noreq", 32'(mem_req), 32'd0);
      cpu_wr_n = 1'b0;
    end else begin
      cpu_rd_n = 1'b0;
    end
    step();
    chk("start_req", 32'(mem_req), 32'd1);
    for (int c = 0; c < 64 && !done; c++) begin
      mem_ack = 1'b0;
      mem_rdata = 8'($urandom);
      if (mem_req && !prev_req) begin
        reqs++; k = 0;
        cap_a = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
      end else if (mem_req) begin
        k++;
      end
      if (!cpu_wait_n) stall++;
      else done = 1;
      if (!done && mem_req && k == lat) begin
        mem_ack = 1'b1;
        mem_rdata = rd;
      end
      prev_req = mem_req;
      if (!done) step();
    end
    mem_ack = 1'b0;
    if (!done) chk("done_budget", 32'd0, 32'd1);
    if (lat < int'(TMO)) begin
      exp_stall = lat + 1;
      if (!wr) exp_di = rd;
    end else begin
      exp_stall = int'(TMO);
      exp_di = 8'hFF;
      exp_err = 1'b1;
    end
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("req_count", 32'(reqs), 32'd1);
    chk("addr", 32'(cap_a), 32'(a));
    chk("we", 32'(cap_we), 32'(wr));
    if (wr) chk("wdata", 32'(cap_wd), 32'(d));
    chk("di", 32'(cpu_di), 32'(exp_di));
    chk("bus_err", 32'(bus_err), 32'(exp_err));
    chk("req_dropped", 32'(mem_req), 32'd0);
    // Strobes stay low; stray acks must not disturb anything.
    for (int h = 0; h < hold; h++) begin
      mem_ack = 1'($urandom);
      mem_rdata = 8'($urandom);
      step();
      if (mem_req) extra++;
      if (!cpu_wait_n) bad_wait++;
    end
    mem_ack = 1'b0;
    chk("no_second_req", 32'(extra), 32'd0);
    chk("hold_wait", 32'(bad_wait), 32'd0);
    chk("hold_di", 32'(cpu_di), 32'(exp_di));
    bus_idle();
    step();
    chk("release_noreq", 32'(mem_req), 32'd0);
  endtask

  task automatic do_refresh();
    int bad = 0;
    cpu_mreq_n = 1'b0; cpu_rfsh_n = 1'b0; cpu_rd_n = 1'($urandom);
    cpu_a = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'($urandom);
      step();
      if (mem_req || !cpu_wait_n) bad++;
    end
    mem_ack = 1'b0;
    chk("refresh_quiet", 32'(bad), 32'd0);
    bus_idle();
    step();
  endtask

  task automatic do_io(input bit intack);
    int bad = 0;
    cpu_iorq_n = 1'b0;
    cpu_m1_n = intack ? 1'b0 : 1'b1;
    cpu_rd_n = intack ? 1'b1 : 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (mem_req || !cpu_wait_n) bad++;
    end
    exp_di = 8'hFF;
    chk(intack ? "intack_quiet" : "iord_quiet", 32'(bad), 32'd0);
    chk(intack ? "intack_di" : "iord_di", 32'(cpu_di), 32'(exp_di));
    bus_idle();
    step();
  endtask

  task automatic do_reset_mid();
    cpu_a = 16'h1234; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    step(); step(); step();
    chk("rst_mid_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    step();
    exp_di = 8'hFF; exp_err = 1'b0;
    chk("rst_mid_req_drop", 32'(mem_req), 32'd0);
    chk("rst_mid_wait", 32'(cpu_wait_n), 32'd1);
    chk("rst_mid_di", 32'(cpu_di), 32'(exp_di));
    chk("rst_mid_err", 32'(bus_err), 32'(exp_err));
    reset = 1'b0;
    step();
    chk("rst_fresh_req", 32'(mem_req), 32'd1);
    chk("rst_fresh_addr", 32'(mem_addr), 32'h1234);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    step();
    mem_ack = 1'b0;
    exp_di = 8'h5A;
    chk("rst_fresh_wait", 32'(cpu_wait_n), 32'd1);
    chk("rst_fresh_di", 32'(cpu_di), 32'(exp_di));
    bus_idle();
    step();
  endtask

  initial begin
    reset = 1'b1;
    bus_idle();
    cpu_a = '0; cpu_dout = '0; mem_rdata = '0; mem_ack = 1'b0;
    step(); step();
    chk("rst_wait", 32'(cpu_wait_n), 32'd1);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_di", 32'(cpu_di), 32'hFF);
    chk("rst_err", 32'(bus_err), 32'd0);
    reset = 1'b0;
    step();

    do_mem(1'b0, 16'h4000, 8'h00, 3, 8'hA5, 0);
    do_mem(1'b1, 16'h8001, 8'h3C, 2, 8'h00, 1);
    do_refresh();
    do_io(1'b0);
    do_io(1'b1);
    do_mem(1'b0, 16'h2222, 8'h00, 30, 8'h77, 0);
    do_mem(1'b0, 16'h3333, 8'h00, 1, 8'h66, 2);
    do_mem(1'b0, 16'h4444, 8'h00, int'(TMO) - 1, 8'h99, 0);
    do_mem(1'b0, 16'h5555, 8'h00, 0, 8'h11, 10);
    do_reset_mid();

    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = int'($urandom_range(0, 6));
      if (kind <= 2) do_mem(1'b0, 16'($urandom), 8'($urandom), int'($urandom_range(0, 18)),
                            8'($urandom), int'($urandom_range(0, 4)));
      else if (kind == 3) do_mem(1'b1, 16'($urandom), 8'($urandom), int'($urandom_range(0, 18)),
                                 8'($urandom), int'($urandom_range(0, 4)));
      else if (kind == 4) do_refresh();
      else do_io(kind == 6);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        mem_ack = 1'($urandom);
        step();
        chk("gap_noreq", 32'(mem_req), 32'd0);
      end
      mem_ack = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
